// File: rtl/stack_pointer_module.sv
// ---------------------------------------------------------------------------
// stack_pointer_module
// Descending hardware stack pointer for the URCPU. Push pre-decrements SP and
// writes at the new SP; pop reads at SP and post-increments. Tracks depth,
// full/empty and sticky overflow/underflow errors.
//
// Ports:
//   clk         in   system clock, rising-edge updates
//   rst         in   synchronous active-high reset
//   push        in   push request
//   pop         in   pop request (push+pop together = exchange top)
//   load        in   overwrite SP with load_value (highest priority after rst)
//   load_value  in   WIDTH  value written to SP on load
//   clear_err   in   clear sticky overflow/underflow flags
//   sp          out  WIDTH  current SP register
//   addr        out  WIDTH  combinational memory address for this cycle's op
//   depth       out  WIDTH  STACK_TOP - sp (combinational)
//   empty       out  sp >= STACK_TOP
//   full        out  sp <= STACK_LIMIT
//   borrow_out  out  borrow of sp - 1 (set only when sp == 0)
//   op_done     out  registered pulse: previous cycle's push/pop was accepted
//   overflow    out  sticky: push attempted while full
//   underflow   out  sticky: pop attempted while empty
// ---------------------------------------------------------------------------
module stack_pointer_module #(
    parameter int unsigned           WIDTH       = 20,
    parameter logic [WIDTH-1:0]      STACK_TOP   = 'h10000,
    parameter logic [WIDTH-1:0]      STACK_LIMIT = 'h0F000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clear_err,
    output logic [WIDTH-1:0] sp,
    output logic [WIDTH-1:0] addr,
    output logic [WIDTH-1:0] depth,
    output logic             empty,
    output logic             full,
    output logic             borrow_out,
    output logic             op_done,
    output logic             overflow,
    output logic             underflow
);

    // Registered state
    logic [WIDTH-1:0] r_sp;
    logic             r_op_done;
    logic             r_overflow;
    logic             r_underflow;

    // Next-state and datapath wires
    logic [WIDTH-1:0] w_sp_next;
    logic             w_op_done_next;
    logic             w_overflow_next;
    logic             w_underflow_next;
    logic [WIDTH:0]   w_sp_dec_ext;
    logic [WIDTH-1:0] w_sp_dec;
    logic [WIDTH-1:0] w_sp_inc;
    logic             w_empty;
    logic             w_full;
    logic             w_push_only;
    logic             w_pop_only;
    logic             w_exchange;
    logic             w_set_ovf;
    logic             w_set_udf;

    // Decrement with an extra bit so the borrow falls out of the MSB
    assign w_sp_dec_ext = {1'b0, r_sp} - (WIDTH+1)'(1);
    assign w_sp_dec     = w_sp_dec_ext[WIDTH-1:0];
    assign w_sp_inc     = r_sp + WIDTH'(1);

    // Range checks; an out-of-range loaded SP reads as full or empty
    assign w_empty = (r_sp >= STACK_TOP);
    assign w_full  = (r_sp <= STACK_LIMIT);

    // Operation decode; load masks push/pop for the cycle
    assign w_push_only = !load &&  push && !pop;
    assign w_pop_only  = !load && !push &&  pop;
    assign w_exchange  = !load &&  push &&  pop;

    // Error conditions; exchange on a full stack is legal
    assign w_set_ovf = w_push_only && w_full;
    assign w_set_udf = (w_pop_only || w_exchange) && w_empty;

    // Next-state logic
    always_comb begin
        w_sp_next        = r_sp;
        w_op_done_next   = 1'b0;
        w_overflow_next  = r_overflow;
        w_underflow_next = r_underflow;

        if (load) begin
            w_sp_next = load_value;
        end else if (w_push_only) begin
            if (!w_full) begin
                w_sp_next      = w_sp_dec;
                w_op_done_next = 1'b1;
            end
        end else if (w_pop_only) begin
            if (!w_empty) begin
                w_sp_next      = w_sp_inc;
                w_op_done_next = 1'b1;
            end
        end else if (w_exchange) begin
            w_op_done_next = !w_empty;
        end

        // Set beats clear in the same cycle
        if (clear_err) begin
            w_overflow_next  = 1'b0;
            w_underflow_next = 1'b0;
        end
        if (w_set_ovf) begin
            w_overflow_next = 1'b1;
        end
        if (w_set_udf) begin
            w_underflow_next = 1'b1;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp        <= STACK_TOP;
            r_op_done   <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_sp        <= w_sp_next;
            r_op_done   <= w_op_done_next;
            r_overflow  <= w_overflow_next;
            r_underflow <= w_underflow_next;
        end
    end

    // Address: only an accepted push points below SP
    always_comb begin
        addr = r_sp;
        if (w_push_only && !w_full) begin
            addr = w_sp_dec;
        end
    end

    assign sp         = r_sp;
    assign depth      = STACK_TOP - r_sp;
    assign empty      = w_empty;
    assign full       = w_full;
    assign borrow_out = w_sp_dec_ext[WIDTH];
    assign op_done    = r_op_done;
    assign overflow   = r_overflow;
    assign underflow  = r_underflow;

endmodule

// File: tb/tb_stack_pointer_module.sv
module tb_stack_pointer_module;

    localparam int unsigned WIDTH = 20;

    logic             clk;
    logic             rst;
    logic             push;
    logic             pop;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             clear_err;
    logic [WIDTH-1:0] sp;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] depth;
    logic             empty;
    logic             full;
    logic             borrow_out;
    logic             op_done;
    logic             overflow;
    logic             underflow;

    int n_checks = 0;
    int n_pass   = 0;

    stack_pointer_module #(
        .WIDTH       (WIDTH),
        .STACK_TOP   (20'h10000),
        .STACK_LIMIT (20'h0F000)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .load       (load),
        .load_value (load_value),
        .clear_err  (clear_err),
        .sp         (sp),
        .addr       (addr),
        .depth      (depth),
        .empty      (empty),
        .full       (full),
        .borrow_out (borrow_out),
        .op_done    (op_done),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; push = 1'b0; pop = 1'b0; load = 1'b0;
        load_value = '0; clear_err = 1'b0;
        step(); step();
        rst = 1'b0;
        step(); step();

        // Reset state
        check("rst_sp",      32'(sp), 32'h10000);
        check("rst_empty",   32'(empty), 1);
        check("rst_full",    32'(full), 0);
        check("rst_depth",   32'(depth), 0);
        check("rst_op_done", 32'(op_done), 0);
        check("rst_ovf",     32'(overflow), 0);
        check("rst_udf",     32'(underflow), 0);
        check("rst_addr",    32'(addr), 32'h10000);
        check("rst_borrow",  32'(borrow_out), 0);

        // Three pushes
        push = 1'b1; #1;
        check("push1_addr", 32'(addr), 32'h0FFFF);
        step();
        check("push1_done", 32'(op_done), 1);
        check("push1_sp",   32'(sp), 32'h0FFFF);
        check("push2_addr", 32'(addr), 32'h0FFFE);
        step();
        check("push2_done", 32'(op_done), 1);
        check("push3_addr", 32'(addr), 32'h0FFFD);
        step();
        push = 1'b0; #1;
        check("push3_done",  32'(op_done), 1);
        check("push3_sp",    32'(sp), 32'h0FFFD);
        check("push3_depth", 32'(depth), 3);
        check("push3_empty", 32'(empty), 0);
        step();
        check("idle_done", 32'(op_done), 0);

        // Pop one back
        pop = 1'b1; #1;
        check("pop_addr", 32'(addr), 32'h0FFFD);
        step();
        pop = 1'b0; #1;
        check("pop_sp",   32'(sp), 32'h0FFFE);
        check("pop_done", 32'(op_done), 1);

        // Fill to the limit, then overflow
        load = 1'b1; load_value = 20'h0F001; step();
        load = 1'b0; #1;
        check("ld_sp",   32'(sp), 32'h0F001);
        check("ld_done", 32'(op_done), 0);
        check("ld_full", 32'(full), 0);
        push = 1'b1; #1;
        check("lim_addr", 32'(addr), 32'h0F000);
        step();
        check("lim_sp",   32'(sp), 32'h0F000);
        check("lim_full", 32'(full), 1);
        check("lim_done", 32'(op_done), 1);
        check("full_addr", 32'(addr), 32'h0F000);
        step();
        push = 1'b0; #1;
        check("ovf_sp",   32'(sp), 32'h0F000);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_done", 32'(op_done), 0);

        // Set wins over clear in the same cycle
        push = 1'b1; clear_err = 1'b1; step();
        push = 1'b0; #1;
        check("set_over_clr", 32'(overflow), 1);
        step();
        clear_err = 1'b0; #1;
        check("clr_ovf", 32'(overflow), 0);

        // Exchange on a full stack is not an error
        push = 1'b1; pop = 1'b1; #1;
        check("xfull_addr", 32'(addr), 32'h0F000);
        step();
        push = 1'b0; pop = 1'b0; #1;
        check("xfull_done", 32'(op_done), 1);
        check("xfull_ovf",  32'(overflow), 0);
        check("xfull_sp",   32'(sp), 32'h0F000);

        // Underflow from reset, then exchange on empty
        rst = 1'b1; step();
        rst = 1'b0;
        pop = 1'b1; step();
        check("udf_flag", 32'(underflow), 1);
        check("udf_sp",   32'(sp), 32'h10000);
        check("udf_done", 32'(op_done), 0);
        push = 1'b1; step();
        push = 1'b0; pop = 1'b0; #1;
        check("xempty_udf",  32'(underflow), 1);
        check("xempty_sp",   32'(sp), 32'h10000);
        check("xempty_done", 32'(op_done), 0);

        // Load beats push; clear_err alongside load clears flags
        load = 1'b1; load_value = 20'h0FFFE; push = 1'b1; clear_err = 1'b1; step();
        load = 1'b0; push = 1'b0; clear_err = 1'b0; #1;
        check("ldpri_sp",   32'(sp), 32'h0FFFE);
        check("ldpri_done", 32'(op_done), 0);
        check("ldpri_udf",  32'(underflow), 0);

        // Exchange top from 0FFFE
        push = 1'b1; pop = 1'b1; #1;
        check("xchg_addr", 32'(addr), 32'h0FFFE);
        step();
        push = 1'b0; pop = 1'b0; #1;
        check("xchg_sp",   32'(sp), 32'h0FFFE);
        check("xchg_done", 32'(op_done), 1);
        check("xchg_ovf",  32'(overflow), 0);
        check("xchg_udf",  32'(underflow), 0);

        // Out-of-range load of zero
        load = 1'b1; load_value = 20'h00000; step();
        load = 1'b0; #1;
        check("zero_borrow", 32'(borrow_out), 1);
        check("zero_full",   32'(full), 1);
        check("zero_empty",  32'(empty), 0);
        check("zero_depth",  32'(depth), 32'h10000);
        push = 1'b1; step();
        push = 1'b0; #1;
        check("zero_ovf", 32'(overflow), 1);
        check("zero_sp",  32'(sp), 0);

        // Reset takes priority over a concurrent pop
        rst = 1'b1; pop = 1'b1; step();
        rst = 1'b0; pop = 1'b0; #1;
        check("rstpop_sp",   32'(sp), 32'h10000);
        check("rstpop_ovf",  32'(overflow), 0);
        check("rstpop_udf",  32'(underflow), 0);
        check("rstpop_done", 32'(op_done), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
